// File: rtl/ps2_ascii_in.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines, deframes set-2 scancodes,
// queues them and translates make codes to ASCII behind a valid/ready output stage.
module ps2_ascii_in #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ascii_ready,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic       parity_err,
    output logic       overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, POP, DEC} state_t;

    function automatic logic [7:0] key_to_ascii(input logic [7:0] code,
                                                input logic shift_on,
                                                input logic caps_on);
        logic [7:0] ch;
        logic       letter;
        ch     = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            default: letter = 1'b0;
        endcase
        // Letters fold to uppercase by clearing bit 5; caps lock never affects digits.
        if (letter && (shift_on ^ caps_on)) ch = ch - 8'd32;
        if (!letter) begin
            case (code)
                8'h45: ch = shift_on ? ")" : "0";
                8'h16: ch = shift_on ? "!" : "1";
                8'h1E: ch = shift_on ? "@" : "2";
                8'h26: ch = shift_on ? "#" : "3";
                8'h25: ch = shift_on ? "$" : "4";
                8'h2E: ch = shift_on ? "%" : "5";
                8'h36: ch = shift_on ? "^" : "6";
                8'h3D: ch = shift_on ? "&" : "7";
                8'h3E: ch = shift_on ? "*" : "8";
                8'h46: ch = shift_on ? "(" : "9";
                8'h29: ch = 8'h20;
                8'h5A: ch = 8'h0A;
                8'h66: ch = 8'h08;
                default: ch = 8'h00;
            endcase
        end
        return ch;
    endfunction

    logic [2:0]       clk_sync, data_sync;
    logic             clk_prev, fall;
    logic [3:0]       bit_cnt;
    logic [10:0]      shreg, frame_next;
    logic             frame_ok;
    logic [TMO_W-1:0] timer;
    logic [7:0]       byte_p1;
    logic             vld_p1;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, push_ok;
    state_t           state_q, state_d;
    logic [7:0]       code_reg, dec_char;
    logic             shift, caps, brk, ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 3'b111;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            clk_prev <= clk_sync[2];
        end
    end

    always_ff @(posedge clk) data_sync <= {data_sync[1:0], ps2_data};

    assign fall       = clk_prev & ~clk_sync[2];
    assign frame_next = {data_sync[2], shreg[10:1]};
    assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

    // Stage p0 -> p1: deframing; a complete frame is checked on its 11th falling edge.
    always_ff @(posedge clk) begin
        if (fall) begin
            shreg   <= frame_next;
            byte_p1 <= frame_next[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            timer      <= '0;
            vld_p1     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            vld_p1     <= 1'b0;
            parity_err <= 1'b0;
            if (fall) begin
                timer <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    vld_p1     <= frame_ok;
                    parity_err <= ~frame_ok;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != '0) begin
                if (timer == TMO_W'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    timer   <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

    // Stage p1 -> FIFO: a pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop     = (state_q == POP);
    assign push_ok = vld_p1 & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= byte_p1;
        if (pop) code_reg <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (vld_p1 && full && !pop) overflow <= 1'b1;
        end
    end

    // FIFO -> decoder: IDLE waits for data and a free output slot, POP reads, DEC acts.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count != '0 && (!ascii_valid || ascii_ready)) state_d = POP;
            POP:     state_d = DEC;
            DEC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dec_char = key_to_ascii(code_reg, shift, caps);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift       <= 1'b0;
            caps        <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            ascii_valid <= 1'b0;
            ascii_out   <= 8'h00;
        end else begin
            if (ascii_valid && ascii_ready) ascii_valid <= 1'b0;
            if (state_q == DEC) begin
                if (code_reg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code_reg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    if (code_reg == 8'h12 || code_reg == 8'h59) shift <= 1'b0;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (ext) begin
                    ext <= 1'b0;
                end else if (code_reg == 8'h12 || code_reg == 8'h59) begin
                    shift <= 1'b1;
                end else if (code_reg == 8'h58) begin
                    caps <= ~caps;
                end else if (dec_char != 8'h00) begin
                    ascii_out   <= dec_char;
                    ascii_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_ascii_in.sv
// Scoreboard bench for ps2_ascii_in: bit-banged PS/2 frames, a keyboard-level reference
// model pushing expected characters, and a monitor checking every accepted output.
module tb_ps2_ascii_in;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ascii_ready = 1'b1;
    logic [7:0] ascii_out;
    logic       ascii_valid, parity_err, overflow;

    ps2_ascii_in #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ascii_ready(ascii_ready), .ascii_out(ascii_out), .ascii_valid(ascii_valid),
        .parity_err(parity_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    bit   mon_en = 0, rand_ready = 0, ready_force = 1;
    int   vcount = 0, perr_seen = 0, perr_exp = 0;
    bit   prev_hold = 0, prev_perr = 0;
    logic [7:0] prev_out = 8'h00;

    // Keyboard model state and the set-2 tables
    bit m_shift = 0, m_caps = 0, m_brk = 0, m_ext = 0;
    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
        8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,
        8'h22,8'h35,8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    string sym = ")!@#$%^&*(";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] translate(input logic [7:0] b);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) return (m_shift ^ m_caps) ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) return m_shift ? 8'(sym[i]) : 8'(48 + i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0A;
        if (b == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] ch;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (m_brk) begin
            if (b == 8'h12 || b == 8'h59) m_shift = 0;
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) m_ext = 0;
        else if (b == 8'h12 || b == 8'h59) m_shift = 1;
        else if (b == 8'h58) m_caps = ~m_caps;
        else begin
            ch = translate(b);
            if (ch != 8'h00) q.push_back(ch);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~(^b) ^ bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        wait_cyc(20);
    endtask

    task automatic key(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (q.size() != 0 && i < 3000) begin
            wait_cyc(1);
            i++;
        end
        wait_cyc(20);
        chk(name, q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ascii_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares each accepted character and the hold behaviour under back-pressure.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ascii_valid) vcount++;
            if (parity_err) begin
                perr_seen++;
                chk("parity_err_width", prev_perr, 1'b0);
            end
            prev_perr = parity_err;
            if (prev_hold) begin
                chk("hold_valid", ascii_valid, 1'b1);
                chk("hold_data", ascii_out, prev_out);
            end
            if (ascii_valid && ascii_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_char: got 0x%0h, expected none", ascii_out);
                end else begin
                    chk("char", ascii_out, q.pop_front());
                end
            end
            prev_hold = ascii_valid && !ascii_ready;
            prev_out  = ascii_out;
        end
    end

    initial begin
        int v0;
        int r;
        logic [7:0] b;
        wait_cyc(5);
        @(negedge clk);
        chk("rst_out", ascii_out, 8'h00);
        chk("rst_valid", ascii_valid, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1;
        wait_cyc(5);

        // Single key, valid for exactly one cycle
        v0 = vcount;
        key(8'h1C);
        wait_drain("t1_drain");
        chk("t1_valid_cycles", vcount - v0, 1);

        // Shifted key with breaks: one 'A', then shift must be released
        v0 = vcount;
        key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
        wait_drain("t2_drain");
        chk("t2_valid_cycles", vcount - v0, 1);
        key(8'h1C);
        wait_drain("t2_shift_released");

        // Caps lock, shift cancelling caps, shifted digit, then restore
        key(8'h58); key(8'hF0); key(8'h58); key(8'h1C);
        key(8'h12); key(8'h1C);
        key(8'h12); key(8'h16);
        key(8'hF0); key(8'h12); key(8'h58);
        wait_drain("t3_drain");

        // Bad parity frame dropped, next good frame decoded
        send_frame(8'h1C, 1'b1);
        perr_exp++;
        key(8'h5A);
        wait_drain("t4_drain");
        chk("t4_perr_count", perr_seen, perr_exp);
        chk("t4_no_overflow", overflow, 1'b0);

        // Back-pressure: output holds, FIFO fills, overflow sticks
        ready_force = 0;
        wait_cyc(2);
        for (int i = 0; i < 12; i++) begin
            if (i < 1 + FIFO_DEPTH) model_byte(8'h1C);
            send_frame(8'h1C, 1'b0);
        end
        @(negedge clk);
        chk("t5_held_valid", ascii_valid, 1'b1);
        chk("t5_held_data", ascii_out, 8'h61);
        chk("t5_overflow", overflow, 1'b1);
        #1;
        ready_force = 1;
        wait_drain("t5_drain");

        // Extended keys ignored; partial frame aborted by timeout
        key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        wait_cyc(TIMEOUT_CYC + 1);
        key(8'h29);
        wait_drain("t6_drain");
        chk("t6_perr_count", perr_seen, perr_exp);

        // Randomised key stream with random back-pressure
        rand_ready = 1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3, 4: key(letter_codes[$urandom_range(0, 25)]);
                5: key(digit_codes[$urandom_range(0, 9)]);
                6: begin
                    b = ($urandom_range(0, 1) == 1) ? 8'h29 : 8'h66;
                    if ($urandom_range(0, 2) == 0) b = 8'h05;
                    key(b);
                end
                7: begin
                    if ($urandom_range(0, 1) == 1) key(8'hF0);
                    key(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
                end
                8: begin
                    key(8'hF0);
                    key(letter_codes[$urandom_range(0, 25)]);
                end
                9: begin
                    key(8'hE0);
                    key(8'h75);
                end
                10: key(8'h58);
                default: begin
                    send_frame(letter_codes[$urandom_range(0, 25)], 1'b1);
                    perr_exp++;
                end
            endcase
        end
        rand_ready = 0;
        ready_force = 1;
        wait_drain("rand_drain");
        chk("rand_perr_count", perr_seen, perr_exp);
        chk("final_overflow_sticky", overflow, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
